// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port program ROM arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned ROM_LAST_DEF = 254;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_OP = 1'b1
  } port_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  err;
  } rsp_entry_t;

endpackage

// File: rtl/rom_rsp_fifo.sv
// Show-ahead response FIFO; head entry is presented whenever valid_o is high.
module rom_rsp_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = rd_en_i && (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  // Empty FIFO presents zero so idle outputs never show stale storage.
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(wr_en_i) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates IF and OP reads onto one registered-output ROM, with credit-
// limited in-order response FIFOs per port (accept-to-response = 3 cycles).
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ROM_LAST   = ROM_LAST_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              op_req_valid,
  output logic              op_req_ready,
  input  logic [ADDR_W-1:0] op_req_addr,
  output logic              op_rsp_valid,
  input  logic              op_rsp_ready,
  output logic [DATA_W-1:0] op_rsp_data,
  output logic              op_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]     cnt_if_q, cnt_if_d, cnt_op_q, cnt_op_d;
  port_e             rr_last_q, rr_last_d;
  logic              elig_if, elig_op, gnt_if, gnt_op, acc, acc_err;
  port_e             acc_tag;
  logic [ADDR_W-1:0] acc_addr, rom_addr_q;
  logic              s1_vld_q, s1_err_q, s2_vld_q, s2_err_q;
  port_e             s1_tag_q, s2_tag_q;
  logic              hs_if, hs_op, wr_if, wr_op;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W:0]   wr_entry, if_head, op_head;

  always_comb begin
    elig_if  = if_req_valid && (cnt_if_q < CW'(FIFO_DEPTH));
    elig_op  = op_req_valid && (cnt_op_q < CW'(FIFO_DEPTH));
    gnt_if   = 1'b0;
    gnt_op   = 1'b0;
    if (elig_if && elig_op) begin
      if ((RR_MODE != 0) && (rr_last_q == PORT_OP)) gnt_if = 1'b1;
      else                                          gnt_op = 1'b1;
    end else begin
      gnt_if = elig_if;
      gnt_op = elig_op;
    end
    acc       = gnt_if || gnt_op;
    acc_tag   = gnt_op ? PORT_OP : PORT_IF;
    acc_addr  = gnt_op ? op_req_addr : if_req_addr;
    acc_err   = (acc_addr > ADDR_W'(ROM_LAST));
    rr_last_d = acc ? acc_tag : rr_last_q;
  end

  assign if_req_ready = gnt_if;
  assign op_req_ready = gnt_op;
  assign hs_if        = if_rsp_valid && if_rsp_ready;
  assign hs_op        = op_rsp_valid && op_rsp_ready;
  // Credits cover in-flight reads too, so a FIFO write can never find it full.
  assign cnt_if_d     = cnt_if_q + CW'(gnt_if) - CW'(hs_if);
  assign cnt_op_d     = cnt_op_q + CW'(gnt_op) - CW'(hs_op);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_if_q   <= '0;
      cnt_op_q   <= '0;
      rr_last_q  <= PORT_OP;
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_tag_q   <= PORT_IF;
      s2_vld_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_tag_q   <= PORT_IF;
    end else begin
      cnt_if_q  <= cnt_if_d;
      cnt_op_q  <= cnt_op_d;
      rr_last_q <= rr_last_d;
      if (acc && !acc_err) rom_addr_q <= acc_addr;
      s1_vld_q <= acc;
      s1_err_q <= acc_err;
      s1_tag_q <= acc_tag;
      s2_vld_q <= s1_vld_q;
      s2_err_q <= s1_err_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  assign rom_addr = rom_addr_q;
  assign wr_data  = s2_err_q ? '0 : rom_data;
  assign wr_entry = {wr_data, s2_err_q};
  assign wr_if    = s2_vld_q && (s2_tag_q == PORT_IF);
  assign wr_op    = s2_vld_q && (s2_tag_q == PORT_OP);

  rom_rsp_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_if_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_if),
    .wr_data_i (wr_entry),
    .rd_en_i   (if_rsp_ready),
    .valid_o   (if_rsp_valid),
    .rd_data_o (if_head)
  );

  rom_rsp_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_op_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_op),
    .wr_data_i (wr_entry),
    .rd_en_i   (op_rsp_ready),
    .valid_o   (op_rsp_valid),
    .rd_data_o (op_head)
  );

  assign {if_rsp_data, if_rsp_err} = if_head;
  assign {op_rsp_data, op_rsp_err} = op_head;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a behavioural registered ROM.
module tb_rom_port_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAST  = 254;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_ready = 1'b0, if_rsp_err;
  logic          op_req_valid = 1'b0, op_req_ready, op_rsp_valid, op_rsp_ready = 1'b0, op_rsp_err;
  logic [AW-1:0] if_req_addr = '0, op_req_addr = '0, rom_addr;
  logic [DW-1:0] if_rsp_data, op_rsp_data, rom_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic [DW-1:0] rom_mem [256];
  exp_t          q_if[$];
  exp_t          q_op[$];
  exp_t          mon_e;
  logic [AW-1:0] rom_m = '0;
  int            checks = 0;
  int            errors = 0;

  rom_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_LAST(LAST), .FIFO_DEPTH(DEPTH), .RR_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .op_req_valid(op_req_valid), .op_req_ready(op_req_ready), .op_req_addr(op_req_addr),
    .op_rsp_valid(op_rsp_valid), .op_rsp_ready(op_rsp_ready), .op_rsp_data(op_rsp_data),
    .op_rsp_err(op_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr[7:0]];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    e.err  = (a > AW'(LAST));
    e.data = e.err ? '0 : rom_mem[a[7:0]];
    return e;
  endfunction

  // Handshakes are stable at the falling edge and complete on the next rising edge.
  always @(negedge clk) begin
    chk_val("rom_addr", rom_addr, rom_m);
    chk_val("one_grant", {31'd0, if_req_ready & op_req_ready}, 0);
    if (!rst) begin
      q_if.delete();
      q_op.delete();
      rom_m = '0;
    end else begin
      if (if_rsp_valid && if_rsp_ready) begin
        if (q_if.size() == 0) chk_val("if_unexpected_rsp", q_if.size(), 1);
        else begin
          mon_e = q_if.pop_front();
          chk_val("if_data", if_rsp_data, mon_e.data);
          chk_val("if_err", if_rsp_err, mon_e.err);
        end
      end
      if (op_rsp_valid && op_rsp_ready) begin
        if (q_op.size() == 0) chk_val("op_unexpected_rsp", q_op.size(), 1);
        else begin
          mon_e = q_op.pop_front();
          chk_val("op_data", op_rsp_data, mon_e.data);
          chk_val("op_err", op_rsp_err, mon_e.err);
        end
      end
      if (if_req_valid && if_req_ready) begin
        mon_e = model(if_req_addr);
        q_if.push_back(mon_e);
        if (!mon_e.err) rom_m = if_req_addr;
      end
      if (op_req_valid && op_req_ready) begin
        mon_e = model(op_req_addr);
        q_op.push_back(mon_e);
        if (!mon_e.err) rom_m = op_req_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    if_rsp_ready = 1'b1;
    op_rsp_ready = 1'b1;
    for (int i = 0; i < 60 && (q_if.size() + q_op.size()) != 0; i++) tick();
    tick();
    chk_val("drain", q_if.size() + q_op.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic          last_op;
    logic          acc_i, acc_o;
    logic [AW-1:0] t4 [3];

    for (int unsigned i = 0; i < 256; i++) rom_mem[i] = 16'hA000 | 16'(i);
    rom_mem[0]   = 16'h1300;
    rom_mem[1]   = 16'h0000;
    rom_mem[2]   = 16'h0000;
    rom_mem[3]   = 16'h1400;
    rom_mem[4]   = 16'h0000;
    rom_mem[12]  = 16'h1702;
    rom_mem[13]  = 16'h007F;
    rom_mem[16]  = 16'h3BD8;
    rom_mem[254] = 16'h0000;
    rom_mem[255] = 16'hDEAD;

    // Reset state
    repeat (2) tick();
    chk_val("rst_if_ready", if_req_ready, 0);
    chk_val("rst_op_ready", op_req_ready, 0);
    chk_val("rst_if_valid", if_rsp_valid, 0);
    chk_val("rst_op_valid", op_rsp_valid, 0);
    chk_val("rst_if_data", if_rsp_data, 0);
    chk_val("rst_op_data", op_rsp_data, 0);
    chk_val("rst_if_err", if_rsp_err, 0);
    chk_val("rst_op_err", op_rsp_err, 0);
    rst = 1'b1;
    tick();

    // 1: single IF read, latency 3
    if_rsp_ready = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 16'd0;
    #1;
    chk_val("t1_ready", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    chk_val("t1_lat0", if_rsp_valid, 0);
    tick();
    chk_val("t1_lat1", if_rsp_valid, 0);
    tick();
    chk_val("t1_lat2", if_rsp_valid, 1);
    chk_val("t1_data", if_rsp_data, 16'h1300);
    chk_val("t1_err", if_rsp_err, 0);
    tick();
    chk_val("t1_popped", if_rsp_valid, 0);

    // 2: both ports streaming, round-robin alternation
    op_rsp_ready = 1'b1;
    if_req_addr  = 16'd12;
    op_req_addr  = 16'd13;
    if_req_valid = 1'b1;
    op_req_valid = 1'b1;
    last_op      = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk_val("t2_rr_if", if_req_ready, last_op);
      chk_val("t2_rr_op", op_req_ready, !last_op);
      last_op = !last_op;
      tick();
    end
    if_req_valid = 1'b0;
    op_req_valid = 1'b0;
    drain();

    // 3: OP consumer stalled; credits block only OP
    op_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      op_req_valid = 1'b1;
      op_req_addr  = 16'(k);
      #1;
      chk_val("t3_op_acc", op_req_ready, 1);
      tick();
    end
    op_req_addr  = 16'd4;
    if_req_valid = 1'b1;
    if_req_addr  = 16'd12;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_val("t3_op_held", op_req_ready, 0);
      chk_val("t3_if_served", if_req_ready, 1);
      tick();
    end
    if_req_valid = 1'b0;
    repeat (3) tick();
    chk_val("t3_op_still_held", op_req_ready, 0);
    op_rsp_ready = 1'b1;
    for (int i = 0; i < 10 && !op_req_ready; i++) tick();
    chk_val("t3_op5_acc", op_req_ready, 1);
    tick();
    op_req_valid = 1'b0;
    drain();

    // 4: out-of-range addresses
    t4[0] = 16'h00FF;
    t4[1] = 16'h1234;
    t4[2] = 16'h00FE;
    for (int k = 0; k < 3; k++) begin
      if_req_valid = 1'b1;
      if_req_addr  = t4[k];
      #1;
      chk_val("t4_acc", if_req_ready, 1);
      tick();
    end
    if_req_valid = 1'b0;
    drain();

    // 5: reset with two reads in flight
    if_req_valid = 1'b1;
    if_req_addr  = 16'd12;
    tick();
    if_req_valid = 1'b0;
    op_req_valid = 1'b1;
    op_req_addr  = 16'd13;
    tick();
    op_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_val("t5_if_none", if_rsp_valid, 0);
      chk_val("t5_op_none", op_rsp_valid, 0);
      tick();
    end
    op_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      op_req_valid = 1'b1;
      op_req_addr  = 16'd16;
      #1;
      chk_val("t5_credit_acc", op_req_ready, 1);
      tick();
    end
    chk_val("t5_credit_full", op_req_ready, 0);
    op_req_valid = 1'b0;
    tick();
    chk_val("t5_op16_data", op_rsp_data, 16'h3BD8);
    drain();

    // 6: IF full, then accepts overlapping pops, then random traffic
    if_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_req_valid = 1'b1;
      if_req_addr  = 16'(20 + k);
      #1;
      chk_val("t6_fill", if_req_ready, 1);
      tick();
    end
    if_req_addr = 16'd24;
    repeat (4) tick();
    chk_val("t6_full_block", if_req_ready, 0);
    if_rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc_i = if_req_valid && if_req_ready;
      @(posedge clk);
      #1;
      if (acc_i) if_req_addr = if_req_addr + 16'd1;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc_i = if_req_valid && if_req_ready;
      acc_o = op_req_valid && op_req_ready;
      @(posedge clk);
      #1;
      if (acc_i || !if_req_valid) begin
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = 16'($urandom_range(0, 260));
      end
      if (acc_o || !op_req_valid) begin
        op_req_valid = ($urandom_range(0, 3) != 0);
        op_req_addr  = 16'($urandom_range(0, 260));
      end
      if_rsp_ready = ($urandom_range(0, 9) < 3);
      op_rsp_ready = ($urandom_range(0, 1) == 1);
    end
    if_req_valid = 1'b0;
    op_req_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
